// File: rtl/dmac_pkg.sv
// Shared definitions for the DMA master: state encoding, address modes,
// descriptor layout and small address-step helpers.
package dmac_pkg;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int SIZE_W   = 16;
  localparam int DESC_W   = 48;
  localparam int SRC_LSB  = 32;
  localparam int DEST_LSB = 16;
  localparam int SIZE_LSB = 0;

  localparam logic [1:0] MODE_INC_INC = 2'b00;
  localparam logic [1:0] MODE_FIX_SRC = 2'b01;
  localparam logic [1:0] MODE_FIX_DST = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dest;
    logic [SIZE_W-1:0] size;
  } desc_t;

  function automatic desc_t desc_unpack(input logic [DESC_W-1:0] raw);
    desc_t d;
    d.src  = raw[SRC_LSB  +: ADDR_W];
    d.dest = raw[DEST_LSB +: ADDR_W];
    d.size = raw[SIZE_LSB +: SIZE_W];
    return d;
  endfunction

  // Mode 11 is not a distinct mode: it increments both sides like 00.
  function automatic logic src_inc(input logic [1:0] mode);
    return (mode != MODE_FIX_SRC);
  endfunction

  function automatic logic dest_inc(input logic [1:0] mode);
    return (mode != MODE_FIX_DST);
  endfunction

endpackage

// File: rtl/dmac_addr_gen.sv
// Source/destination/size counters for one descriptor; addresses advance
// per op_mode with 16-bit wrap on every granted write.
module dmac_addr_gen
  import dmac_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [1:0]        op_mode,
  input  desc_t             desc,
  output logic [ADDR_W-1:0] dest,
  output logic [ADDR_W-1:0] src_nxt,
  output logic              last
);

  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dest_nxt;
  logic [SIZE_W-1:0] size;

  assign src_nxt  = src  + {{(ADDR_W-1){1'b0}}, src_inc(op_mode)};
  assign dest_nxt = dest + {{(ADDR_W-1){1'b0}}, dest_inc(op_mode)};
  assign last     = (size == SIZE_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src  <= '0;
      dest <= '0;
      size <= '0;
    end else if (load) begin
      src  <= desc.src;
      dest <= desc.dest;
      size <= desc.size;
    end else if (step) begin
      src  <= src_nxt;
      dest <= dest_nxt;
      size <= size - SIZE_W'(1);
    end
  end

endmodule

// File: rtl/dmac_master.sv
// Descriptor-driven DMA bus master: pops {src,dest,size}, copies word by word.
// Optional macro DMAC_MASTER_XFER_CNT_EN adds the xfer_cnt write counter port.
module dmac_master
  import dmac_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_start,
  input  logic              op_clear,
  input  logic [1:0]        op_mode,
  input  logic              empty,
  output logic              rd_en,
  input  logic [DESC_W-1:0] fifo_dout,
  output logic              m_req,
  input  logic              m_grant,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din,
  output logic              op_done
`ifdef DMAC_MASTER_XFER_CNT_EN
  ,
  output logic [SIZE_W-1:0] xfer_cnt
`endif
);

  state_t            state_q;
  desc_t             desc;
  logic [DATA_W-1:0] data_buf;
  logic [ADDR_W-1:0] dest;
  logic [ADDR_W-1:0] src_nxt;
  logic              last;
  logic              load;
  logic              step;

  assign desc   = desc_unpack(fifo_dout);
  assign load   = (state_q == ST_LOAD);
  assign step   = (state_q == ST_WRITE) && m_grant;
  assign m_dout = data_buf;

  dmac_addr_gen u_addr_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .step    (step),
    .op_mode (op_mode),
    .desc    (desc),
    .dest    (dest),
    .src_nxt (src_nxt),
    .last    (last)
  );

  // Bus outputs are set on the transition into READ/WRITE so they are
  // already valid, and then frozen, for the whole wait-for-grant period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rd_en    <= 1'b0;
      m_req    <= 1'b0;
      m_wr     <= 1'b0;
      m_addr   <= '0;
      data_buf <= '0;
      op_done  <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (op_start && !empty) begin
            state_q <= ST_POP;
            rd_en   <= 1'b1;
          end
        end
        ST_POP: state_q <= ST_LOAD;
        ST_LOAD: begin
          if (desc.size == '0) begin
            state_q <= ST_NEXT;
          end else begin
            state_q <= ST_READ;
            m_req   <= 1'b1;
            m_wr    <= 1'b0;
            m_addr  <= desc.src;
          end
        end
        ST_READ: begin
          if (m_grant) begin
            data_buf <= m_din;
            m_wr     <= 1'b1;
            m_addr   <= dest;
            state_q  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (m_grant) begin
            m_wr <= 1'b0;
            if (last) begin
              m_req   <= 1'b0;
              state_q <= ST_NEXT;
            end else begin
              m_addr  <= src_nxt;
              state_q <= ST_READ;
            end
          end
        end
        // Dropping op_start wins over an empty queue: the run was disabled,
        // so it ends quietly in IDLE rather than raising op_done.
        ST_NEXT: begin
          if (!op_start) begin
            state_q <= ST_IDLE;
          end else if (empty) begin
            state_q <= ST_DONE;
            op_done <= 1'b1;
          end else begin
            state_q <= ST_POP;
            rd_en   <= 1'b1;
          end
        end
        ST_DONE: begin
          if (op_clear) begin
            op_done <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef DMAC_MASTER_XFER_CNT_EN
  // Counts across all descriptors of one run; a new run starts at IDLE->POP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xfer_cnt <= '0;
    end else if ((state_q == ST_IDLE) && op_start && !empty) begin
      xfer_cnt <= '0;
    end else if (step) begin
      xfer_cnt <= xfer_cnt + SIZE_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dmac_master.sv
// Self-checking bench for dmac_master: FIFO and bus slave models, a transaction
// scoreboard computed from descriptor rules, directed tables and random runs.
`timescale 1ns/1ps
module tb_dmac_master;
  import dmac_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_start = 1'b0;
  logic        op_clear = 1'b0;
  logic [1:0]  op_mode = 2'b00;
  logic        empty = 1'b1;
  logic        rd_en;
  logic [47:0] fifo_dout = '0;
  logic        m_req;
  logic        m_grant = 1'b0;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [31:0] m_dout;
  logic [31:0] m_din;
  logic        op_done;
`ifdef DMAC_MASTER_XFER_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  dmac_master dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op_start  (op_start),
    .op_clear  (op_clear),
    .op_mode   (op_mode),
    .empty     (empty),
    .rd_en     (rd_en),
    .fifo_dout (fifo_dout),
    .m_req     (m_req),
    .m_grant   (m_grant),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .m_dout    (m_dout),
    .m_din     (m_din),
    .op_done   (op_done)
`ifdef DMAC_MASTER_XFER_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdata(input logic [15:0] a);
    return {a ^ 16'h5A3C, ~a};
  endfunction
  assign m_din = rdata(m_addr);

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
  } xact_t;

  typedef struct {
    logic [15:0] src;
    logic [15:0] dest;
    logic [15:0] size;
    logic [1:0]  mode;
    bit          rnd;
    logic [15:0] exp_last_rd;
    logic [15:0] exp_last_wr;
    int          exp_writes;
  } vec_t;

  xact_t       log_q[$];
  xact_t       exp_q[$];
  logic [47:0] fq[$];
  int          errors = 0;
  int          checks = 0;
  int          pops = 0;
  bit          gnt_rand = 0;
  bit          rd_block = 0;
  int          wr_hold = 0;
  bit          snap_v = 0;
  logic [49:0] snap;
  int          total_wr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of the environment: FIFO pop, grant policy, bus logging.
  task automatic step();
    xact_t x;
    @(negedge clk);
    if (rd_en) begin
      pops++;
      check("rd_en_while_empty", {63'd0, empty}, 64'd0);
      if (fq.size() > 0) fifo_dout = fq.pop_front();
    end
    empty = (fq.size() == 0);
    if (m_req && m_wr && wr_hold > 0) begin
      if (!snap_v) begin
        snap   = {m_req, m_wr, m_addr, m_dout};
        snap_v = 1;
      end else begin
        check("hold_stable", {14'd0, m_req, m_wr, m_addr, m_dout}, {14'd0, snap});
      end
      m_grant = 1'b0;
      wr_hold--;
    end else if (m_req && !m_wr && rd_block) begin
      m_grant = 1'b0;
    end else begin
      m_grant = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (m_req && m_grant) begin
      x.wr   = m_wr;
      x.addr = m_addr;
      x.data = m_wr ? m_dout : m_din;
      log_q.push_back(x);
    end
  endtask

  task automatic push_desc(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    fq.push_back({s, d, n});
    empty = 1'b0;
  endtask

  // Reference: each word is one read at s followed by one write of that word at d.
  task automatic model_desc(input logic [15:0] s_in, input logic [15:0] d_in,
                            input logic [15:0] n, input logic [1:0] mode);
    logic [15:0] s;
    logic [15:0] d;
    xact_t x;
    s = s_in;
    d = d_in;
    for (int i = 0; i < int'(n); i++) begin
      x = '{1'b0, s, rdata(s)};
      exp_q.push_back(x);
      x = '{1'b1, d, rdata(s)};
      exp_q.push_back(x);
      if (mode != 2'b01) s = s + 16'd1;
      if (mode != 2'b10) d = d + 16'd1;
    end
  endtask

  function automatic int n_writes();
    int c = 0;
    foreach (log_q[i]) if (log_q[i].wr) c++;
    return c;
  endfunction

  function automatic logic [15:0] last_addr(input bit wr);
    logic [15:0] a = '0;
    foreach (log_q[i]) if (log_q[i].wr == wr) a = log_q[i].addr;
    return a;
  endfunction

  task automatic compare_log(input string name);
    check({name, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      check({name, "_xact"}, {15'd0, log_q[i]}, {15'd0, exp_q[i]});
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic run_until_done(input int budget, input string name);
    int n = 0;
    while (!op_done && n < budget) begin
      step();
      n++;
    end
    check({name, "_done"}, {63'd0, op_done}, 64'd1);
  endtask

  task automatic finish_done(input string name);
    repeat (3) step();
    check({name, "_done_held"}, {62'd0, op_done, m_req}, {62'd0, 1'b1, 1'b0});
    op_clear = 1'b1;
    step();
    op_clear = 1'b0;
    step();
    check({name, "_done_clr"}, {63'd0, op_done}, 64'd0);
  endtask

  vec_t vec[5];

  initial begin
    vec[0] = '{16'h0010, 16'h0100, 16'd3, 2'b00, 1'b0, 16'h0012, 16'h0102, 3};
    vec[1] = '{16'h0020, 16'h0200, 16'd2, 2'b01, 1'b0, 16'h0020, 16'h0201, 2};
    vec[2] = '{16'hFFFF, 16'h1000, 16'd2, 2'b00, 1'b1, 16'h0000, 16'h1001, 2};
    vec[3] = '{16'h0300, 16'hFFFE, 16'd3, 2'b10, 1'b1, 16'h0302, 16'hFFFE, 3};
    vec[4] = '{16'h0400, 16'h0500, 16'd1, 2'b11, 1'b0, 16'h0400, 16'h0500, 1};

    // Reset values
    repeat (3) step();
    check("rst_ctrl", {60'd0, rd_en, m_req, m_wr, op_done}, 64'd0);
    check("rst_addr", 64'(m_addr), 64'd0);
    check("rst_dout", 64'(m_dout), 64'd0);
    check("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
    reset_n = 1'b1;
    step();

    // Enabled but nothing queued: no pop, no bus activity
    op_start = 1'b1;
    repeat (4) step();
    check("idle_empty", {62'd0, m_req, op_done}, 64'd0);
    check("idle_empty_pops", 64'(pops), 64'd0);

    foreach (vec[k]) begin
      op_mode  = vec[k].mode;
      gnt_rand = vec[k].rnd;
      pops     = 0;
      model_desc(vec[k].src, vec[k].dest, vec[k].size, vec[k].mode);
      push_desc(vec[k].src, vec[k].dest, vec[k].size);
      run_until_done(200, "vec");
      check("vec_pops", 64'(pops), 64'd1);
      check("vec_last_rd", 64'(last_addr(1'b0)), 64'(vec[k].exp_last_rd));
      check("vec_last_wr", 64'(last_addr(1'b1)), 64'(vec[k].exp_last_wr));
      check("vec_writes", 64'(n_writes()), 64'(vec[k].exp_writes));
`ifdef DMAC_MASTER_XFER_CNT_EN
      check("vec_xfer_cnt", 64'(xfer_cnt), 64'(vec[k].exp_writes));
`endif
      compare_log("vec");
      finish_done("vec");
    end

    // Second descriptor has size 0: popped, skipped, then DONE
    op_mode = 2'b00; gnt_rand = 0; pops = 0;
    model_desc(16'h0030, 16'h0300, 16'd2, 2'b00);
    push_desc(16'h0030, 16'h0300, 16'd2);
    push_desc(16'h0035, 16'h0350, 16'd0);
    run_until_done(200, "zero");
    check("zero_pops", 64'(pops), 64'd2);
    compare_log("zero");
    finish_done("zero");

    // Grant withheld for 5 cycles in the first WRITE
    wr_hold = 5; snap_v = 0; pops = 0;
    model_desc(16'h0040, 16'h0400, 16'd2, 2'b00);
    push_desc(16'h0040, 16'h0400, 16'd2);
    run_until_done(200, "hold");
    check("hold_consumed", 64'(wr_hold), 64'd0);
    compare_log("hold");
    finish_done("hold");

    // op_start dropped mid-descriptor: current descriptor completes, then IDLE
    pops = 0;
    model_desc(16'h0050, 16'h0500, 16'd3, 2'b00);
    push_desc(16'h0050, 16'h0500, 16'd3);
    push_desc(16'h0060, 16'h0600, 16'd1);
    for (int n = 0; n < 20 && !m_req; n++) step();
    check("stop_started", {63'd0, m_req}, 64'd1);
    op_start = 1'b0;
    repeat (30) step();
    check("stop_idle", {62'd0, m_req, op_done}, 64'd0);
    check("stop_pops", 64'(pops), 64'd1);
    compare_log("stop");
    op_start = 1'b1;
    model_desc(16'h0060, 16'h0600, 16'd1, 2'b00);
    run_until_done(200, "resume");
    check("resume_pops", 64'(pops), 64'd2);
`ifdef DMAC_MASTER_XFER_CNT_EN
    check("resume_xfer_cnt", 64'(xfer_cnt), 64'd1);
`endif
    compare_log("resume");
    finish_done("resume");

    // Randomised runs of 1-3 queued descriptors with random grant
    gnt_rand = 1;
    for (int it = 0; it < 20; it++) begin
      int nd;
      logic [15:0] s, d, n;
      op_mode  = 2'($urandom_range(0, 3));
      nd       = $urandom_range(1, 3);
      pops     = 0;
      total_wr = 0;
      for (int j = 0; j < nd; j++) begin
        s = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF)) : 16'($urandom);
        d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF)) : 16'($urandom);
        n = 16'($urandom_range(0, 4));
        total_wr += int'(n);
        model_desc(s, d, n, op_mode);
        push_desc(s, d, n);
      end
      run_until_done(600, "rand");
      check("rand_pops", 64'(pops), 64'(nd));
`ifdef DMAC_MASTER_XFER_CNT_EN
      check("rand_xfer_cnt", 64'(xfer_cnt), 64'(total_wr));
`endif
      compare_log("rand");
      finish_done("rand");
    end
    gnt_rand = 0;

    // Reset pulsed while a READ waits for grant
    op_mode = 2'b00; pops = 0;
    push_desc(16'h0070, 16'h0700, 16'd2);
    for (int n = 0; n < 20 && n_writes() == 0; n++) step();
    rd_block = 1;
    for (int n = 0; n < 20 && !(m_req && !m_wr); n++) step();
    check("rst_mid_in_read", {62'd0, m_req, m_wr}, {62'd0, 1'b1, 1'b0});
`ifdef DMAC_MASTER_XFER_CNT_EN
    check("rst_mid_cnt_before", 64'(xfer_cnt), 64'd1);
`endif
    step();
    reset_n = 1'b0;
    fq.delete();
    step();
    check("rst_mid_ctrl", {60'd0, rd_en, m_req, m_wr, op_done}, 64'd0);
    check("rst_mid_addr", 64'(m_addr), 64'd0);
    check("rst_mid_dout", 64'(m_dout), 64'd0);
    check("rst_mid_state", 64'(dut.state_q), 64'(ST_IDLE));
`ifdef DMAC_MASTER_XFER_CNT_EN
    check("rst_mid_cnt", 64'(xfer_cnt), 64'd0);
`endif
    rd_block = 0;
    reset_n  = 1'b1;
    repeat (5) step();
    check("rst_mid_after", {62'd0, m_req, op_done}, 64'd0);
    check("rst_mid_writes", 64'(n_writes()), 64'd1);
    log_q.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
